// File: rtl/sha3_job_feeder.sv
// sha3_job_feeder: host-side driver for one sha3_scanner.
// Collects a 26-word job, starts the scanner, follows it through dispatch
// and drain, then streams back a result packet: status, absolute nonce and
// (on success) the leading hash words.
module sha3_job_feeder #(
    parameter int HASH_WORDS       = 8,
    parameter int DISPATCH_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // job word stream from host
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_data,
    // scanner interface
    output logic [23:0][31:0]     scn_blobby,
    output logic [63:0]           scn_threshold,
    output logic                  scn_start,
    input  logic                  scn_ready,
    input  logic                  scn_dispatching,
    input  logic                  scn_found,
    input  logic [31:0]           scn_nonce,
    input  logic [49:0][31:0]     scn_hash,
    // result word stream to host
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_data,
    output logic                  out_last,
    output logic                  busy
);

    localparam int IDX_W = $clog2(HASH_WORDS + 2);
    localparam int TMR_W = $clog2(DISPATCH_TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_FOUND = IDX_W'(HASH_WORDS + 1);
    localparam logic [IDX_W-1:0] LAST_SHORT = IDX_W'(1);
    localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(DISPATCH_TIMEOUT - 1);
    localparam int NONCE_WORD = 21;

    typedef enum logic [2:0] {
        S_LOAD,
        S_START,
        S_WAIT_DISP,
        S_RUN,
        S_REPORT
    } state_t;

    state_t                       state_q, state_d;
    logic [4:0]                   word_cnt_q, word_cnt_d;
    logic [15:0]                  job_id_q, job_id_d;
    logic [TMR_W-1:0]             timer_q, timer_d;
    logic                         in_ready_q, in_ready_d;
    logic [23:0][31:0]            blobby_q, blobby_d;
    logic [63:0]                  threshold_q, threshold_d;
    logic                         found_q, found_d;
    logic                         timeout_q, timeout_d;
    logic [31:0]                  nonce_q, nonce_d;
    logic [HASH_WORDS-1:0][31:0]  hash_q, hash_d;
    logic [IDX_W-1:0]             out_idx_q, out_idx_d;

    // Only the first HASH_WORDS scanner hash words are ever returned.
    logic unused_hash;
    assign unused_hash = ^scn_hash;

    assign in_ready      = in_ready_q;
    assign scn_blobby    = blobby_q;
    assign scn_threshold = threshold_q;
    assign busy          = (state_q != S_LOAD);

    // State and datapath registers; reset discards any job in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_LOAD;
            word_cnt_q  <= '0;
            job_id_q    <= '0;
            timer_q     <= '0;
            in_ready_q  <= 1'b0;
            blobby_q    <= '0;
            threshold_q <= '0;
            found_q     <= 1'b0;
            timeout_q   <= 1'b0;
            nonce_q     <= '0;
            hash_q      <= '0;
            out_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            job_id_q    <= job_id_d;
            timer_q     <= timer_d;
            in_ready_q  <= in_ready_d;
            blobby_q    <= blobby_d;
            threshold_q <= threshold_d;
            found_q     <= found_d;
            timeout_q   <= timeout_d;
            nonce_q     <= nonce_d;
            hash_q      <= hash_d;
            out_idx_q   <= out_idx_d;
        end
    end

    // Next-state logic, job capture, scanner handshake and packet emission.
    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        job_id_d    = job_id_q;
        timer_d     = timer_q;
        blobby_d    = blobby_q;
        threshold_d = threshold_q;
        found_d     = found_q;
        timeout_d   = timeout_q;
        nonce_d     = nonce_q;
        hash_d      = hash_q;
        out_idx_d   = out_idx_q;
        scn_start   = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        out_data    = '0;

        case (state_q)
            S_LOAD: begin
                if (in_valid && in_ready_q) begin
                    for (int i = 0; i < 24; i++) begin
                        if (word_cnt_q == 5'(i)) blobby_d[i] = in_data;
                    end
                    if (word_cnt_q == 5'd24) threshold_d[31:0]  = in_data;
                    if (word_cnt_q == 5'd25) threshold_d[63:32] = in_data;
                    if (word_cnt_q == 5'd25) begin
                        word_cnt_d = '0;
                        state_d    = S_START;
                    end else begin
                        word_cnt_d = word_cnt_q + 5'd1;
                    end
                end
            end

            S_START: begin
                // start is only offered while the scanner can take it, so
                // the pulse and the capture always coincide.
                scn_start = scn_ready;
                if (scn_ready) begin
                    timer_d   = '0;
                    timeout_d = 1'b0;
                    state_d   = S_WAIT_DISP;
                end
            end

            S_WAIT_DISP: begin
                // scn_ready lingers briefly after capture; only dispatching
                // proves the scanner has actually begun.
                timer_d = timer_q + 1'b1;
                if (scn_dispatching) begin
                    state_d = S_RUN;
                end else if (timer_q == TMR_LAST) begin
                    timeout_d = 1'b1;
                    found_d   = 1'b0;
                    nonce_d   = '0;
                    out_idx_d = '0;
                    state_d   = S_REPORT;
                end
            end

            S_RUN: begin
                // Drained: no dispatch in flight and scanner idle again.
                if (!scn_dispatching && scn_ready) begin
                    found_d   = scn_found;
                    timeout_d = 1'b0;
                    nonce_d   = scn_found ? (blobby_q[NONCE_WORD] + scn_nonce) : '0;
                    for (int i = 0; i < HASH_WORDS; i++) hash_d[i] = scn_hash[i];
                    out_idx_d = '0;
                    state_d   = S_REPORT;
                end
            end

            S_REPORT: begin
                // All packet fields come from registers, so data/last hold
                // naturally while the host stalls.
                out_valid = 1'b1;
                out_last  = found_q ? (out_idx_q == LAST_FOUND) : (out_idx_q == LAST_SHORT);
                if (out_idx_q == '0) begin
                    out_data = {found_q, timeout_q, 14'b0, job_id_q};
                end else if (out_idx_q == IDX_W'(1)) begin
                    out_data = nonce_q;
                end else begin
                    for (int i = 0; i < HASH_WORDS; i++) begin
                        if (out_idx_q == IDX_W'(i + 2)) out_data = hash_q[i];
                    end
                end
                if (out_ready) begin
                    if (out_last) begin
                        out_idx_d = '0;
                        job_id_d  = job_id_q + 16'd1;
                        state_d   = S_LOAD;
                    end else begin
                        out_idx_d = out_idx_q + 1'b1;
                    end
                end
            end

            default: state_d = S_LOAD;
        endcase

        in_ready_d = (state_d == S_LOAD);
    end

endmodule
